vga_rect_fill: RTL and testbench

VGA_RECT_FILL -- requirements
Module: vga_rect_fill

---
 rtl/vga_rect_fill_pkg.sv | 14 +
 rtl/vga.svh | 8 +
 rtl/vga_rect_clip.sv | 26 ++
 rtl/vga_rect_fill.sv | 124 ++++++++++++
 tb/tb_vga_rect_fill.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_rect_fill_pkg.sv
// vga_rect_fill_pkg: coordinate types and visible-area limits for the fill engine
`include "vga.svh"
package vga_rect_fill_pkg;
   typedef logic [`H_SIZE-1:0] hpos_t;
   typedef logic [`V_SIZE-1:0] vpos_t;
   localparam hpos_t X_LAST = hpos_t'(`H_DISPLAY - 1);
   localparam vpos_t Y_LAST = vpos_t'(`V_DISPLAY - 1);
   typedef struct packed {
      hpos_t xmin;
      hpos_t xmax;
      vpos_t ymin;
      vpos_t ymax;
   } rect_t;
endpackage

// File: rtl/vga.svh
// vga.svh: shared VGA display geometry and coordinate widths
`ifndef VGA_SVH
`define VGA_SVH
`define H_DISPLAY 640
`define V_DISPLAY 480
`define H_SIZE 10
`define V_SIZE 10
`endif

// File: rtl/vga_rect_clip.sv
// vga_rect_clip: orders rectangle corners and clamps the far edges to the screen
`include "vga.svh"
module vga_rect_clip
   import vga_rect_fill_pkg::*;
(
   input  logic [`H_SIZE-1:0] x0,
   input  logic [`H_SIZE-1:0] x1,
   input  logic [`V_SIZE-1:0] y0,
   input  logic [`V_SIZE-1:0] y1,
   output rect_t              r,
   output logic               off_screen
);
   hpos_t xhi;
   vpos_t yhi;
   // near edges are plain minimums; far edges are clamped to the last visible pixel
   always_comb begin
      r = '0;
      xhi = (x0 < x1) ? x1 : x0;
      yhi = (y0 < y1) ? y1 : y0;
      r.xmin = (x0 < x1) ? x0 : x1;
      r.ymin = (y0 < y1) ? y0 : y1;
      r.xmax = (xhi > X_LAST) ? X_LAST : xhi;
      r.ymax = (yhi > Y_LAST) ? Y_LAST : yhi;
      off_screen = (r.xmin > X_LAST) || (r.ymin > Y_LAST);
   end
endmodule

// File: rtl/vga_rect_fill.sv
// vga_rect_fill: writes a solid rectangle to the frame buffer in raster order
`include "vga.svh"
module vga_rect_fill
   import vga_rect_fill_pkg::*;
#(
   parameter int RGB_SIZE = 12,
   parameter int AVS_DW   = 16
) (
   input  logic                sys_clk,
   input  logic                sys_rst,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic [`H_SIZE-1:0]  cmd_x0,
   input  logic [`H_SIZE-1:0]  cmd_x1,
   input  logic [`V_SIZE-1:0]  cmd_y0,
   input  logic [`V_SIZE-1:0]  cmd_y1,
   input  logic [RGB_SIZE-1:0] cmd_color,
   output logic                src_write,
   output logic [`H_SIZE-1:0]  src_x,
   output logic [`V_SIZE-1:0]  src_y,
   output logic [AVS_DW-1:0]   src_writedata,
   input  logic                src_rdy,
   output logic                busy,
   output logic                done,
   output logic [18:0]         pix_count
);
   typedef enum logic [1:0] {IDLE, SETUP, FILL, DONE} state_t;
   state_t state_q, state_d;
   hpos_t x0_q, x0_d, x1_q, x1_d, xmin_q, xmin_d, xmax_q, xmax_d, src_x_q, src_x_d;
   vpos_t y0_q, y0_d, y1_q, y1_d, ymax_q, ymax_d, src_y_q, src_y_d;
   logic [RGB_SIZE-1:0] color_q, color_d;
   logic [18:0] pix_count_q, pix_count_d;
   rect_t clip_r;
   logic clip_off;
   vga_rect_clip u_clip (
      .x0(x0_q),
      .x1(x1_q),
      .y0(y0_q),
      .y1(y1_q),
      .r(clip_r),
      .off_screen(clip_off)
   );
   assign cmd_ready     = state_q == IDLE;
   assign busy          = (state_q == SETUP) || (state_q == FILL);
   assign done          = state_q == DONE;
   assign src_write     = state_q == FILL;
   assign src_x         = src_x_q;
   assign src_y         = src_y_q;
   assign src_writedata = AVS_DW'(color_q);
   assign pix_count     = pix_count_q;
   // capture command, latch clipped bounds, then walk the raster one accepted write at a time
   always_comb begin
      state_d = state_q;
      x0_d = x0_q;
      x1_d = x1_q;
      y0_d = y0_q;
      y1_d = y1_q;
      color_d = color_q;
      xmin_d = xmin_q;
      xmax_d = xmax_q;
      ymax_d = ymax_q;
      src_x_d = src_x_q;
      src_y_d = src_y_q;
      pix_count_d = pix_count_q;
      case (state_q)
         IDLE: if (cmd_valid) begin
            state_d = SETUP;
            x0_d = cmd_x0;
            x1_d = cmd_x1;
            y0_d = cmd_y0;
            y1_d = cmd_y1;
            color_d = cmd_color;
         end
         SETUP: begin
            state_d = clip_off ? DONE : FILL;
            xmin_d = clip_r.xmin;
            xmax_d = clip_r.xmax;
            ymax_d = clip_r.ymax;
            src_x_d = clip_r.xmin;
            src_y_d = clip_r.ymin;
            pix_count_d = '0;
         end
         FILL: if (src_rdy) begin
            pix_count_d = pix_count_q + 19'd1;
            if (src_x_q != xmax_q) src_x_d = src_x_q + 1'b1;
            else if (src_y_q != ymax_q) begin
               src_x_d = xmin_q;
               src_y_d = src_y_q + 1'b1;
            end else state_d = DONE;
         end
         default: state_d = IDLE;
      endcase
   end
   // state and datapath registers, cleared asynchronously so reset aborts a fill at once
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state_q <= IDLE;
         x0_q <= '0;
         x1_q <= '0;
         y0_q <= '0;
         y1_q <= '0;
         color_q <= '0;
         xmin_q <= '0;
         xmax_q <= '0;
         ymax_q <= '0;
         src_x_q <= '0;
         src_y_q <= '0;
         pix_count_q <= '0;
      end else begin
         state_q <= state_d;
         x0_q <= x0_d;
         x1_q <= x1_d;
         y0_q <= y0_d;
         y1_q <= y1_d;
         color_q <= color_d;
         xmin_q <= xmin_d;
         xmax_q <= xmax_d;
         ymax_q <= ymax_d;
         src_x_q <= src_x_d;
         src_y_q <= src_y_d;
         pix_count_q <= pix_count_d;
      end
   end
endmodule

// File: tb/tb_vga_rect_fill.sv
// tb_vga_rect_fill: directed and randomized fills checked against a raster-list model
`include "vga.svh"
module tb_vga_rect_fill;
   localparam int XL = `H_DISPLAY - 1;
   localparam int YL = `V_DISPLAY - 1;
   typedef struct packed {int x; int y; int d;} pix_t;
   logic sys_clk = 1'b0;
   logic sys_rst, cmd_valid, cmd_ready, src_write, src_rdy, busy, done;
   logic [`H_SIZE-1:0] cmd_x0, cmd_x1, src_x;
   logic [`V_SIZE-1:0] cmd_y0, cmd_y1, src_y;
   logic [11:0] cmd_color;
   logic [15:0] src_writedata;
   logic [18:0] pix_count;
   pix_t exp_q[$];
   int checks = 0;
   int errors = 0;
   int wr_count = 0;
   int rdy_mode = 0;
   int cyc_n = 0;

   vga_rect_fill #(.RGB_SIZE(12), .AVS_DW(16)) dut (
      .sys_clk(sys_clk),
      .sys_rst(sys_rst),
      .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready),
      .cmd_x0(cmd_x0),
      .cmd_x1(cmd_x1),
      .cmd_y0(cmd_y0),
      .cmd_y1(cmd_y1),
      .cmd_color(cmd_color),
      .src_write(src_write),
      .src_x(src_x),
      .src_y(src_y),
      .src_writedata(src_writedata),
      .src_rdy(src_rdy),
      .busy(busy),
      .done(done),
      .pix_count(pix_count)
   );

   always #5 sys_clk = ~sys_clk;

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   // expected write list: every visible pixel of the ordered, clipped rectangle, row by row
   task automatic build(input int x0, input int x1, input int y0, input int y1, input int c, output int n);
      int xa, xb, ya, yb;
      xa = (x0 < x1) ? x0 : x1;
      xb = (x0 < x1) ? x1 : x0;
      ya = (y0 < y1) ? y0 : y1;
      yb = (y0 < y1) ? y1 : y0;
      if (xb > XL) xb = XL;
      if (yb > YL) yb = YL;
      n = 0;
      if (xa <= XL && ya <= YL)
         for (int y = ya; y <= yb; y++)
            for (int x = xa; x <= xb; x++) begin
               exp_q.push_back('{x, y, c});
               n++;
            end
   endtask

   task automatic tick();
      @(posedge sys_clk);
      #1;
      cyc_n++;
      if (rdy_mode == 0) src_rdy = 1'b1;
      else if (rdy_mode == 1) src_rdy = ($urandom_range(0, 2) != 0);
      else src_rdy = (cyc_n % 4 == 0) || (cyc_n % 4 == 3);
   endtask

   task automatic accept(input int x0, input int x1, input int y0, input int y1, input int c, input int mode);
      int w;
      w = 0;
      while (!cmd_ready && w < 50) begin
         tick();
         w++;
      end
      check("ready_before_cmd", int'(cmd_ready), 1);
      rdy_mode = mode;
      cyc_n = 0;
      cmd_valid = 1'b1;
      cmd_x0 = `H_SIZE'(x0);
      cmd_x1 = `H_SIZE'(x1);
      cmd_y0 = `V_SIZE'(y0);
      cmd_y1 = `V_SIZE'(y1);
      cmd_color = 12'(c);
      tick();
      cmd_valid = 1'b0;
      cmd_x0 = `H_SIZE'($urandom);
      cmd_x1 = `H_SIZE'($urandom);
      cmd_y0 = `V_SIZE'($urandom);
      cmd_y1 = `V_SIZE'($urandom);
      cmd_color = 12'($urandom);
      check("busy_after_accept", int'(busy), 1);
   endtask

   task automatic run_cmd(input int x0, input int x1, input int y0, input int y1, input int c, input int mode, input int n);
      int w, first_w;
      accept(x0, x1, y0, y1, c, mode);
      first_w = -1;
      w = 0;
      while (!done && w < 4000) begin
         tick();
         w++;
         if (first_w < 0 && src_write) first_w = w;
      end
      check("done_seen", int'(done), 1);
      if (n == 0) check("empty_done_latency", w, 1);
      else check("first_write_latency", first_w, 1);
      check("pix_count", int'(pix_count), n);
      check("missing_writes", exp_q.size(), 0);
      check("busy_in_done", int'(busy), 0);
      tick();
      check("done_one_cycle", int'(done), 0);
      check("ready_after_done", int'(cmd_ready), 1);
      rdy_mode = 0;
   endtask

   task automatic go(input int x0, input int x1, input int y0, input int y1, input int c, input int mode);
      int n;
      build(x0, x1, y0, y1, c, n);
      run_cmd(x0, x1, y0, y1, c, mode, n);
   endtask

   // per-cycle compare: accepted writes against the model, held outputs during stalls
   initial begin
      pix_t p;
      int hx, hy, hd;
      logic stall;
      stall = 1'b0;
      hx = 0;
      hy = 0;
      hd = 0;
      forever begin
         @(negedge sys_clk);
         if (sys_rst) stall = 1'b0;
         else begin
            if (stall) begin
               check("stall_write_held", int'(src_write), 1);
               check("stall_x_held", int'(src_x), hx);
               check("stall_y_held", int'(src_y), hy);
               check("stall_data_held", int'(src_writedata), hd);
            end
            if (src_write) begin
               check("busy_in_fill", int'(busy), 1);
               check("not_ready_in_fill", int'(cmd_ready), 0);
               if (src_rdy) begin
                  check("write_expected", int'(exp_q.size() != 0), 1);
                  if (exp_q.size() != 0) begin
                     p = exp_q.pop_front();
                     check("write_x", int'(src_x), p.x);
                     check("write_y", int'(src_y), p.y);
                     check("write_data", int'(src_writedata), p.d);
                  end
                  wr_count++;
               end
            end
            if (done) check("no_write_in_done", int'(src_write), 0);
            stall = src_write && !src_rdy;
            hx = int'(src_x);
            hy = int'(src_y);
            hd = int'(src_writedata);
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int n, x0, x1, y0, y1, c, w;
      sys_rst = 1'b1;
      cmd_valid = 1'b0;
      cmd_x0 = '0;
      cmd_x1 = '0;
      cmd_y0 = '0;
      cmd_y1 = '0;
      cmd_color = '0;
      src_rdy = 1'b1;
      tick();
      tick();
      check("rst_src_write", int'(src_write), 0);
      check("rst_src_x", int'(src_x), 0);
      check("rst_src_y", int'(src_y), 0);
      check("rst_wdata", int'(src_writedata), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_pix_count", int'(pix_count), 0);
      check("rst_cmd_ready", int'(cmd_ready), 1);
      sys_rst = 1'b0;
      tick();

      build(2, 0, 1, 0, 'hABC, n);
      check("model_3x2_count", n, 6);
      check("model_3x2_first_x", exp_q[0].x, 0);
      check("model_3x2_row2_x", exp_q[3].x, 0);
      check("model_3x2_row2_y", exp_q[3].y, 1);
      check("model_3x2_last_x", exp_q[5].x, 2);
      check("model_3x2_data", exp_q[5].d, 'hABC);
      run_cmd(2, 0, 1, 0, 'hABC, 0, n);

      build(639, 639, 479, 479, 'h5A5, n);
      check("model_corner_count", n, 1);
      run_cmd(639, 639, 479, 479, 'h5A5, 0, n);

      build(630, 700, 470, 500, 'h0F0, n);
      check("model_clip_count", n, 100);
      check("model_clip_last_x", exp_q[99].x, 639);
      check("model_clip_last_y", exp_q[99].y, 479);
      run_cmd(630, 700, 470, 500, 'h0F0, 1, n);

      build(700, 800, 10, 20, 'h111, n);
      check("model_offscreen_count", n, 0);
      run_cmd(700, 800, 10, 20, 'h111, 0, n);

      build(3, 0, 4, 5, 'hF00, n);
      check("model_4x2_count", n, 8);
      run_cmd(3, 0, 4, 5, 'hF00, 2, n);

      build(0, 9, 5, 5, 'h123, n);
      check("model_reset_row_count", n, 10);
      accept(0, 9, 5, 5, 'h123, 0);
      wr_count = 0;
      w = 0;
      while (wr_count < 3 && w < 100) begin
         tick();
         w++;
      end
      check("writes_before_reset", wr_count, 3);
      sys_rst = 1'b1;
      #1;
      check("midfill_rst_write", int'(src_write), 0);
      check("midfill_rst_busy", int'(busy), 0);
      check("midfill_rst_ready", int'(cmd_ready), 1);
      check("midfill_rst_pix_count", int'(pix_count), 0);
      exp_q.delete();
      tick();
      tick();
      sys_rst = 1'b0;
      tick();
      go(5, 4, 8, 7, 'h246, 0);

      for (int i = 0; i < 30; i++) begin
         x0 = $urandom_range(0, 660);
         y0 = $urandom_range(0, 495);
         x1 = x0 + $urandom_range(0, 9);
         y1 = y0 + $urandom_range(0, 5);
         c = $urandom_range(0, 4095);
         if ($urandom_range(0, 1) == 1) go(x1, x0, y1, y0, c, $urandom_range(0, 1));
         else go(x0, x1, y0, y1, c, $urandom_range(0, 1));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
